// File: rtl/ifft64_pkg.sv
// Shared definitions for the 64-point IFFT output reorder path.
// Holds the transform geometry, the ping-pong bank state encoding and the
// 6-bit bit-reversal used to map radix-2 output order to natural order.
package ifft64_pkg;

    localparam int unsigned N      = 64;
    localparam int unsigned PAIRS  = 32;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_st_e;

    // Reverse the bit order of a 6-bit sample index.
    function automatic logic [ADDR_W-1:0] bitrev6(input logic [ADDR_W-1:0] x);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < int'(ADDR_W); i++) begin
            r[i] = x[int'(ADDR_W) - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_bank.sv
// One 64-entry reorder bank, each entry {re, im}.
// Ports: clk; we writes wdata0/wdata1 at waddr0/waddr1 on the rising edge;
// rdata0_c/rdata1_c are combinational reads at raddr0/raddr1.
// Storage is not reset: a bank is only read after it has been fully written.
module reorder_bank #(
    parameter int unsigned DATA_W = ifft64_pkg::DATA_W
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [ifft64_pkg::ADDR_W-1:0] waddr0,
    input  logic [2*DATA_W-1:0]           wdata0,
    input  logic [ifft64_pkg::ADDR_W-1:0] waddr1,
    input  logic [2*DATA_W-1:0]           wdata1,
    input  logic [ifft64_pkg::ADDR_W-1:0] raddr0,
    output logic [2*DATA_W-1:0]           rdata0_c,
    input  logic [ifft64_pkg::ADDR_W-1:0] raddr1,
    output logic [2*DATA_W-1:0]           rdata1_c
);

    localparam int unsigned ENT_W = 2 * DATA_W;

    logic [ENT_W-1:0] mem_q [ifft64_pkg::N];

    // Both write addresses of a beat always differ in bit 5, so no collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr0] <= wdata0;
            mem_q[waddr1] <= wdata1;
        end
    end

    assign rdata0_c = mem_q[raddr0];
    assign rdata1_c = mem_q[raddr1];

endmodule

// File: rtl/ifft64_output_reorder.sv
// Reorders radix-2 IFFT output pairs (bit-reversed order) into natural order.
// Ports: CLK/ARSTN clock and async active-low reset; in_* pair stream with
// in_valid/in_ready; out_* natural-order pair stream (2j, 2j+1) with
// out_valid/out_ready and out_last on j=31.
// Two banks ping-pong: one fills while the other drains through a one-deep
// registered output stage.
module ifft64_output_reorder #(
    parameter int unsigned DATA_W = ifft64_pkg::DATA_W,
    parameter int unsigned N      = ifft64_pkg::N
) (
    input  logic              CLK,
    input  logic              ARSTN,
    input  logic [DATA_W-1:0] in_re0,
    input  logic [DATA_W-1:0] in_im0,
    input  logic [DATA_W-1:0] in_re1,
    input  logic [DATA_W-1:0] in_im1,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_re0,
    output logic [DATA_W-1:0] out_im0,
    output logic [DATA_W-1:0] out_re1,
    output logic [DATA_W-1:0] out_im1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    import ifft64_pkg::bank_st_e;
    import ifft64_pkg::BANK_EMPTY;
    import ifft64_pkg::BANK_FILLING;
    import ifft64_pkg::BANK_FULL;
    import ifft64_pkg::BANK_DRAINING;
    import ifft64_pkg::bitrev6;

    localparam int unsigned CNT_W  = ifft64_pkg::CNT_W;
    localparam int unsigned ADDR_W = ifft64_pkg::ADDR_W;
    localparam int unsigned ENT_W  = 2 * DATA_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N / 2 - 1);

    bank_st_e          st_q [2];
    bank_st_e          st_d [2];
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_re0_q, out_re0_d;
    logic [DATA_W-1:0] out_im0_q, out_im0_d;
    logic [DATA_W-1:0] out_re1_q, out_re1_d;
    logic [DATA_W-1:0] out_im1_q, out_im1_d;

    logic              wr_fire_c;
    logic              rd_load_c;
    logic [1:0]        we_c;
    logic [ADDR_W-1:0] waddr0_c, waddr1_c, raddr0_c, raddr1_c;
    logic [ENT_W-1:0]  wdata0_c, wdata1_c;
    logic [ENT_W-1:0]  rdata0_c [2];
    logic [ENT_W-1:0]  rdata1_c [2];

    // Beat k lands at bitrev6(2k) and bitrev6(2k)+32; read beat j is 2j, 2j+1.
    always_comb begin
        waddr0_c = bitrev6({wr_cnt_q, 1'b0});
        waddr1_c = {1'b1, waddr0_c[ADDR_W-2:0]};
        raddr0_c = {rd_cnt_q, 1'b0};
        raddr1_c = {rd_cnt_q, 1'b1};
    end

    assign wdata0_c = {in_re0, in_im0};
    assign wdata1_c = {in_re1, in_im1};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign we_c[b] = wr_fire_c && (wr_sel_q == 1'(b));

        reorder_bank #(
            .DATA_W (DATA_W)
        ) u_bank (
            .clk      (CLK),
            .we       (we_c[b]),
            .waddr0   (waddr0_c),
            .wdata0   (wdata0_c),
            .waddr1   (waddr1_c),
            .wdata1   (wdata1_c),
            .raddr0   (raddr0_c),
            .rdata0_c (rdata0_c[b]),
            .raddr1   (raddr1_c),
            .rdata1_c (rdata1_c[b])
        );
    end

    // Bank control: fill side and drain side touch different banks by construction.
    // A bank is released as soon as its final pair has moved into the output
    // register; that pair then completes on the out_last handshake. Releasing
    // at that point lets the next fill start back-to-back without a bubble.
    always_comb begin
        st_d[0]     = st_q[0];
        st_d[1]     = st_q[1];
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_re0_d   = out_re0_q;
        out_im0_d   = out_im0_q;
        out_re1_d   = out_re1_q;
        out_im1_d   = out_im1_q;

        wr_fire_c = in_valid && in_ready_q;
        rd_load_c = (!out_valid_q || out_ready) &&
                    ((st_q[rd_sel_q] == BANK_FULL) || (st_q[rd_sel_q] == BANK_DRAINING));

        if (wr_fire_c) begin
            if (wr_cnt_q == LAST_CNT) begin
                st_d[wr_sel_q] = BANK_FULL;
                wr_cnt_d       = '0;
                wr_sel_d       = ~wr_sel_q;
            end else begin
                st_d[wr_sel_q] = BANK_FILLING;
                wr_cnt_d       = CNT_W'(wr_cnt_q + 1'b1);
            end
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (rd_load_c) begin
            out_valid_d = 1'b1;
            out_last_d  = (rd_cnt_q == LAST_CNT);
            out_re0_d   = rdata0_c[rd_sel_q][ENT_W-1:DATA_W];
            out_im0_d   = rdata0_c[rd_sel_q][DATA_W-1:0];
            out_re1_d   = rdata1_c[rd_sel_q][ENT_W-1:DATA_W];
            out_im1_d   = rdata1_c[rd_sel_q][DATA_W-1:0];
            if (rd_cnt_q == LAST_CNT) begin
                st_d[rd_sel_q] = BANK_EMPTY;
                rd_cnt_d       = '0;
                rd_sel_d       = ~rd_sel_q;
            end else begin
                st_d[rd_sel_q] = BANK_DRAINING;
                rd_cnt_d       = CNT_W'(rd_cnt_q + 1'b1);
            end
        end

        in_ready_d = (st_d[wr_sel_d] == BANK_EMPTY) || (st_d[wr_sel_d] == BANK_FILLING);
    end

    always_ff @(posedge CLK or negedge ARSTN) begin
        if (!ARSTN) begin
            st_q[0]     <= BANK_EMPTY;
            st_q[1]     <= BANK_EMPTY;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re0_q   <= '0;
            out_im0_q   <= '0;
            out_re1_q   <= '0;
            out_im1_q   <= '0;
        end else begin
            st_q[0]     <= st_d[0];
            st_q[1]     <= st_d[1];
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_re0_q   <= out_re0_d;
            out_im0_q   <= out_im0_d;
            out_re1_q   <= out_re1_d;
            out_im1_q   <= out_im1_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_re0   = out_re0_q;
    assign out_im0   = out_im0_q;
    assign out_re1   = out_re1_q;
    assign out_im1   = out_im1_q;

endmodule

// File: tb/tb_ifft64_output_reorder.sv
// Bench for ifft64_output_reorder: natural-order frame model plus literal ramp checks.
module tb_ifft64_output_reorder;

    localparam int DW = 16;

    logic          CLK;
    logic          ARSTN;
    logic [DW-1:0] in_re0, in_im0, in_re1, in_im1;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_re0, out_im0, out_re1, out_im1;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    ifft64_output_reorder #(.DATA_W(DW), .N(64)) dut (
        .CLK       (CLK),
        .ARSTN     (ARSTN),
        .in_re0    (in_re0),
        .in_im0    (in_im0),
        .in_re1    (in_re1),
        .in_im1    (in_im1),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_re0   (out_re0),
        .out_im0   (out_im0),
        .out_re1   (out_re1),
        .out_im1   (out_im1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model state (written only by the compare process)
    logic [DW-1:0] re_buf [64];
    logic [DW-1:0] im_buf [64];
    logic [64:0]   exp_q [$];
    int            part_cnt  = 0;
    int            acc_total = 0;
    int            cyc       = 0;
    int            ramp_cnt  = 0;
    int            gap_cnt   = 0;
    int            fill_cyc  = 0;
    bit            fill_seen = 0;
    bit            lat_done  = 0;
    bit            stall_prev = 0;
    logic [65:0]   prev_out;

    // Driver-owned mode flags
    bit ramp_mode  = 0;
    bit lat_mode   = 0;
    bit cont_feed  = 0;
    int ramp_total = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int tb_bitrev6(input int x);
        int r = 0;
        for (int i = 0; i < 6; i++) begin
            if (((x >> i) & 1) != 0) r += (1 << (5 - i));
        end
        return r;
    endfunction

    // Compare process: tracks accepted inputs, builds expected output pairs, checks every output beat.
    always @(negedge CLK) begin
        logic [63:0] act;
        logic [64:0] e;
        int a0;
        cyc++;
        act = {out_re0, out_im0, out_re1, out_im1};
        if (!ARSTN) begin
            part_cnt = 0;
            exp_q.delete();
            stall_prev = 0;
            ramp_cnt = 0;
            gap_cnt = 0;
            lat_done = 0;
            fill_seen = 0;
            chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
            chk(out_last == 1'b0, "rst_out_last", 64'(out_last), 64'd0);
            chk(act == 64'd0, "rst_out_data", act, 64'd0);
        end else begin
            if (stall_prev) begin
                chk({out_valid, out_last, act} == prev_out, "hold_stable", act, prev_out[63:0]);
            end
            if (lat_mode && fill_seen && !lat_done) begin
                if (cyc == fill_cyc + 1) chk(out_valid == 1'b0, "latency_early", 64'(out_valid), 64'd0);
                if (cyc == fill_cyc + 2) begin
                    chk(out_valid == 1'b1, "latency_rise", 64'(out_valid), 64'd1);
                    lat_done = 1;
                end
            end
            if (ramp_mode && ramp_cnt > 0 && ramp_cnt < ramp_total && !out_valid) gap_cnt++;
            if (cont_feed && in_valid) chk(in_ready == 1'b1, "in_ready_cont", 64'(in_ready), 64'd1);

            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_out", act, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk(act == e[63:0], "out_data", act, e[63:0]);
                    chk(out_last == e[64], "out_last", 64'(out_last), 64'(e[64]));
                end
                if (ramp_mode) begin
                    chk(act == {16'(2 * ramp_cnt), 16'(-2 * ramp_cnt), 16'(2 * ramp_cnt + 1), 16'(-(2 * ramp_cnt + 1))},
                        "ramp_pair", act,
                        {16'(2 * ramp_cnt), 16'(-2 * ramp_cnt), 16'(2 * ramp_cnt + 1), 16'(-(2 * ramp_cnt + 1))});
                    ramp_cnt++;
                end
            end

            if (in_valid && in_ready) begin
                a0 = tb_bitrev6(2 * part_cnt);
                re_buf[a0]      = in_re0;
                im_buf[a0]      = in_im0;
                re_buf[a0 + 32] = in_re1;
                im_buf[a0 + 32] = in_im1;
                part_cnt++;
                acc_total++;
                if (part_cnt == 32) begin
                    for (int j = 0; j < 32; j++) begin
                        exp_q.push_back({(j == 31), re_buf[2*j], im_buf[2*j], re_buf[2*j+1], im_buf[2*j+1]});
                    end
                    part_cnt = 0;
                    if (lat_mode && !fill_seen) begin
                        fill_seen = 1;
                        fill_cyc  = cyc;
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_out   = {out_valid, out_last, act};
        end
    end

    task automatic set_ramp(input int n);
        int idx;
        idx = tb_bitrev6(2 * (n % 32)) + 64 * (n / 32);
        in_re0 = DW'(idx);
        in_im0 = DW'(-idx);
        in_re1 = DW'(idx + 32);
        in_im1 = DW'(-(idx + 32));
    endtask

    task automatic set_rand();
        in_re0 = DW'($urandom);
        in_im0 = DW'($urandom);
        in_re1 = DW'($urandom);
        in_im1 = DW'($urandom);
    endtask

    // kind 0: ramp, ready=1; 1: random data, valid=1, ready held; 2: random valid/ready/data
    task automatic feed(input int nbeats, input int kind, input int budget);
        int base = acc_total;
        int b = budget;
        while ((acc_total - base) < nbeats && b > 0) begin
            @(posedge CLK);
            #1;
            b--;
            if ((acc_total - base) >= nbeats) break;
            case (kind)
                0: begin in_valid = 1'b1; out_ready = 1'b1; set_ramp(acc_total - base); end
                1: begin in_valid = 1'b1; set_rand(); end
                default: begin
                    in_valid  = 1'($urandom % 2);
                    out_ready = 1'($urandom % 2);
                    set_rand();
                end
            endcase
        end
        in_valid = 1'b0;
        if (b == 0) chk(1'b0, "feed_timeout", 64'(acc_total - base), 64'(nbeats));
    endtask

    task automatic drain(input bit rnd, input int budget);
        int b = budget;
        while (exp_q.size() > 0 && b > 0) begin
            @(posedge CLK);
            #1;
            b--;
            out_ready = rnd ? 1'($urandom % 2) : 1'b1;
        end
        if (b == 0) chk(1'b0, "drain_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge CLK);
        chk(out_valid == 1'b0, "drain_idle", 64'(out_valid), 64'd0);
    endtask

    initial begin
        int base;
        ARSTN = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_re0 = '0; in_im0 = '0; in_re1 = '0; in_im1 = '0;
        repeat (3) @(posedge CLK);
        #1 ARSTN = 1'b1;
        @(negedge CLK);
        chk(in_ready == 1'b1, "reset_in_ready", 64'(in_ready), 64'd1);
        chk(out_valid == 1'b0, "reset_out_valid", 64'(out_valid), 64'd0);
        chk(tb_bitrev6(2) == 16, "model_bitrev_2", 64'(tb_bitrev6(2)), 64'd16);
        chk(tb_bitrev6(62) == 31, "model_bitrev_62", 64'(tb_bitrev6(62)), 64'd31);

        // Four back-to-back ramp frames with full throughput
        ramp_total = 128; ramp_mode = 1; lat_mode = 1; cont_feed = 1;
        feed(128, 0, 400);
        cont_feed = 0;
        drain(1'b0, 200);
        chk(gap_cnt == 0, "cont_no_gaps", 64'(gap_cnt), 64'd0);
        chk(ramp_cnt == 128, "cont_beats", 64'(ramp_cnt), 64'd128);
        ramp_mode = 0; lat_mode = 0;

        // Output stalled for 70 cycles while input keeps offering data
        base = acc_total;
        repeat (70) begin
            @(posedge CLK);
            #1;
            out_ready = 1'b0;
            in_valid = 1'b1;
            set_rand();
        end
        @(negedge CLK);
        chk((acc_total - base) == 64, "stall_accepted", 64'(acc_total - base), 64'd64);
        chk(in_ready == 1'b0, "stall_in_ready", 64'(in_ready), 64'd0);
        @(posedge CLK);
        #1 in_valid = 1'b0;
        drain(1'b0, 300);

        // Twenty frames with random valid and random ready
        feed(640, 2, 8000);
        drain(1'b1, 2000);

        // Reset in the middle of a frame with a stored frame pending
        @(posedge CLK);
        #1 out_ready = 1'b0;
        feed(49, 1, 200);
        ARSTN = 1'b0;
        repeat (2) @(posedge CLK);
        #1 ARSTN = 1'b1;
        @(negedge CLK);
        chk(in_ready == 1'b1, "post_rst_in_ready", 64'(in_ready), 64'd1);
        chk(out_valid == 1'b0, "post_rst_out_valid", 64'(out_valid), 64'd0);
        ramp_total = 32; ramp_mode = 1; lat_mode = 1;
        feed(32, 0, 200);
        drain(1'b0, 200);
        chk(ramp_cnt == 32, "post_rst_beats", 64'(ramp_cnt), 64'd32);
        chk(gap_cnt == 0, "post_rst_no_gaps", 64'(gap_cnt), 64'd0);
        ramp_mode = 0; lat_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ifft64_output_reorder.md
IFFT64_OUTPUT_REORDER -- requirements
Module: ifft64_output_reorder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of each real/imag sample component.
REQ-002 SHALL have parameter N, default 64, transform length; only 64 is supported.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port ARSTN  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports in_re0, in_im0, in_re1, in_im1  input  DATA_W each  sample pair from ifft64_radix2 (ifft_out0/ifft_out1 re/im).
REQ-006 SHALL have port in_valid  input  1  input pair present this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts a pair this cycle.
REQ-008 SHALL have ports out_re0, out_im0, out_re1, out_im1  output  DATA_W each  natural-order samples 2j (path 0) and 2j+1 (path 1).
REQ-009 SHALL have port out_valid  output  1  output pair valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the pair.
REQ-011 SHALL have port out_last  output  1  high with pair j=31 of each frame.

Function
REQ-012 SHALL transfer an input beat only when in_valid && in_ready, and an output beat only when out_valid && out_ready.
REQ-013 SHALL treat every 32 accepted input beats as one frame; beat k (0..31) carries path 0 = index bitrev6(2k), path 1 = index bitrev6(2k)+32.
REQ-014 SHALL emit each frame as 32 output beats j=0..31 with path 0 = index 2j, path 1 = index 2j+1, data bit-exact, no scaling.
REQ-015 SHALL use two 64-entry banks in ping-pong; each bank is in state EMPTY, FILLING, FULL or DRAINING.
REQ-016 Bank transitions SHALL be: EMPTY->FILLING on first accepted beat; FILLING->FULL on 32nd beat; FULL->DRAINING when it becomes the read bank; DRAINING->EMPTY on the accepted beat with out_last.
REQ-017 in_ready SHALL be 1 iff the current write bank is EMPTY or FILLING.
REQ-018 When the 32nd input beat is accepted at edge E, out_valid SHALL rise after edge E+1 with j=0 (latency one cycle after frame completion).
REQ-019 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-020 With in_valid=1 and out_ready=1 continuously, the block SHALL sustain one beat per cycle in each direction with no bubbles between frames.
REQ-021 A bank draining its last beat and the other bank completing its fill in the same cycle SHALL both be honoured; the next frame starts without a gap.
REQ-022 Write frame counter and read counter SHALL be 5-bit and wrap 31->0 at frame boundaries; bank select toggles on each wrap.
REQ-023 When both banks are FULL/DRAINING, in_ready SHALL be 0 and no input data is lost or overwritten.

Reset
REQ-024 On ARSTN low, both banks SHALL go EMPTY, counters and bank selects to 0, out_valid=0, out_last=0, out_re*/out_im*=0, in_ready=1 after reset release.
REQ-025 Reset asserted mid-frame SHALL discard all partial and stored frames; the first beat after release is beat k=0 of a new frame.
REQ-026 Bank storage contents SHALL need no reset.

Structure
REQ-027 Shared package ifft64_pkg SHALL hold N=64, PAIRS=32, DATA_W default, the bank state enum, and a bitrev6 function.
REQ-028 One sub-module reorder_bank SHALL implement one 64x(2*DATA_W) bank with two write ports and two read ports; the top instantiates it twice and holds the control FSM.

Verification
REQ-029 Ramp frame: input sample value = its natural index (re=idx, im=-idx), in_valid=1, out_ready=1 -> out pairs (0,1),(2,3)..(62,63), out_last on j=31, first out_valid 1 cycle after the 32nd beat.
REQ-030 Four back-to-back frames with out_ready=1 -> 128 consecutive out_valid cycles, no gaps, in_ready never 0.
REQ-031 out_ready=0 for 70 cycles while feeding -> in_ready drops after 64 accepted beats, out_* stable, all data later correct.
REQ-032 Random out_ready (50%) and random in_valid over 20 frames -> output matches golden bitrev model, no loss/duplication.
REQ-033 ARSTN pulsed low after 17 input beats -> out_valid=0 immediately, following full frame reorders correctly from k=0.
REQ-034 Simultaneous last-drain and last-fill cycle -> next frame j=0 appears the following cycle.
